trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Trap sequencer that consumes the pipeline control unit's error report (`error`, `error_info`, `error_pc`) and turns it into a machine-mode trap entry/exit sequence. It freezes and flushes the five-stage pipeline, writes mtval/mepc/mcause into the external CSR file one register per cycle, redirects the PC to mtvec, and returns to mepc on `mret`. It sits between the pipeline control unit, the CSR file and the PC mux.

## Interface
- `MTVAL_ADDR`, 12'h343, CSR address for mtval
- `MEPC_ADDR`, 12'h341, CSR address for mepc
- `MCAUSE_ADDR`, 12'h342, CSR address for mcause
- `clk`  in  1  CPU clock; all state updates on the rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `error`  in  4  error code; 0 = none, 1 = breakpoint, 2 = divide-by-zero, 3 = memory access, 4 = decode
- `error_info`  in  32  faulting value; written to mtval
- `error_pc`  in  32  faulting instruction PC; written to mepc
- `mret_wb`  in  1  `mret` has retired in WB this cycle
- `mtvec_in`  in  32  current mtvec from the CSR file
- `mepc_in`  in  32  current mepc from the CSR file; may have been modified by the handler
- `freeze`  out  1  holds PC and all pipeline registers (wen = 0)
- `flush`  out  1  clears all pipeline registers
- `pc_redirect`  out  1  one-cycle PC load strobe
- `redirect_pc`  out  32  PC to load when `pc_redirect` = 1
- `csr_we`  out  1  CSR write enable
- `csr_waddr`  out  12  CSR write address
- `csr_wdata`  out  32  CSR write data
- `in_trap`  out  1  a handler is executing
- `double_fault`  out  1  sticky flag; the core is halted
- `trap_count`  out  16  number of trap entries, saturating at 16'hFFFF

## Operation
- States: IDLE, SET_MTVAL, SET_MEPC, SET_MCAUSE, REDIRECT, HANDLER, RETURN, HALT.
- IDLE:
  - If `error` != 0 at a clock edge: latch code, info and pc into internal registers, increment `trap_count` (saturating), go to SET_MTVAL.
  - `mret_wb` in IDLE is ignored.
- SET_MTVAL, SET_MEPC, SET_MCAUSE:
  - Each state lasts one cycle with `freeze` = 1, `flush` = 1, `csr_we` = 1.
  - Address is the matching parameter. Data is the latched info, the latched pc, and mcause respectively.
- mcause mapping by code:
  - 1 → 32'd3
  - 2 → 32'd24
  - 3 → 32'd5
  - 4 → 32'd2
  - 5–15 → 32'd24 + code
- REDIRECT:
  - `freeze` = 0, `flush` = 1, `pc_redirect` = 1, `redirect_pc` = {mtvec_in[31:2], 2'b00} (direct mode only).
  - Next state is HANDLER.
- HANDLER:
  - `in_trap` = 1; the pipeline runs normally.
  - `error` != 0 → HALT. This takes priority over a simultaneous `mret_wb`.
  - Otherwise `mret_wb` → RETURN.
- RETURN:
  - `flush` = 1, `pc_redirect` = 1, `redirect_pc` = {mepc_in[31:2], 2'b00}.
  - Next state is IDLE. `error` sampled in RETURN is ignored.
- HALT:
  - `freeze` = 1, `double_fault` = 1, `in_trap` = 1.
  - The only exit is reset.
- In every state, outputs not listed for that state are 0.
- All outputs are Moore (decoded from state and latched registers), except `redirect_pc` in REDIRECT and RETURN, which reads `mtvec_in` / `mepc_in` combinationally.

## Timing
- Reset (async, any state): state = IDLE; latched registers, `trap_count`, `double_fault` and all outputs = 0. No CSR write completes.
- Latency:
  - `error` sampled at edge N.
  - SET_MTVAL write occurs in cycle N+1, SET_MEPC in N+2, SET_MCAUSE in N+3.
  - PC redirect to mtvec in N+4.
  - First handler instruction is fetched in N+5.
- `csr_we` is asserted in exactly 3 consecutive cycles per trap.
- `error` held high across several cycles triggers one trap only; it is ignored outside IDLE/HANDLER.
- `mret_wb` → RETURN at the next edge; the redirect lasts exactly one cycle.
- Error and mret arriving in the same HANDLER cycle → HALT; no redirect.

## Test plan
- Reset with `error` = 4 held → no CSR write while `rstn` = 0; all outputs 0.
- `error` = 3, info = 32'h0000_1003, pc = 32'h0000_0040, mtvec = 32'h0000_0203, one cycle →
  - writes (343, 1003), (341, 0040), (342, 5) on three consecutive cycles;
  - `pc_redirect` with 32'h0000_0200 on the next cycle;
  - `trap_count` = 1.
- Trap entry, then `mret_wb` with mepc_in = 32'h0000_0044 → one-cycle `pc_redirect` to 32'h0000_0044 with `flush`, then IDLE and `in_trap` = 0.
- In HANDLER, `error` = 2 together with `mret_wb` → HALT; `double_fault` = 1 and `freeze` = 1 persist until reset.
- `error` = 1 held for 6 cycles → exactly 3 CSR writes, mcause = 3, `trap_count` = 1.
- Reset asserted during SET_MEPC → immediate IDLE, `csr_we` = 0, `trap_count` = 0.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: error report -> CSR writes -> mtvec redirect.
// Freezes/flushes the pipeline during entry, returns to mepc on mret.
//
// Ports:
//   clk, rstn          clock, async active-low reset
//   error[3:0]         error code (0 = none)
//   error_info[31:0]   faulting value, written to mtval
//   error_pc[31:0]     faulting PC, written to mepc
//   mret_wb            mret retired in WB this cycle
//   mtvec_in[31:0]     current mtvec from the CSR file
//   mepc_in[31:0]      current mepc from the CSR file
//   freeze, flush      pipeline hold / clear
//   pc_redirect        one-cycle PC load strobe
//   redirect_pc[31:0]  PC to load when pc_redirect = 1
//   csr_we/waddr/wdata CSR write port
//   in_trap            a handler is executing
//   double_fault       sticky halt flag
//   trap_count[15:0]   saturating trap entry counter

module trap_sequencer #(
    parameter logic [11:0] MTVAL_ADDR  = 12'h343,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  error,
    input  logic [31:0] error_info,
    input  logic [31:0] error_pc,
    input  logic        mret_wb,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    output logic        freeze,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        in_trap,
    output logic        double_fault,
    output logic [15:0] trap_count
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SET_MTVAL  = 3'd1;
    localparam logic [2:0] S_SET_MEPC   = 3'd2;
    localparam logic [2:0] S_SET_MCAUSE = 3'd3;
    localparam logic [2:0] S_REDIRECT   = 3'd4;
    localparam logic [2:0] S_HANDLER    = 3'd5;
    localparam logic [2:0] S_RETURN     = 3'd6;
    localparam logic [2:0] S_HALT       = 3'd7;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [3:0]  code_q;
    logic [31:0] info_q;
    logic [31:0] pc_q;
    logic [31:0] mcause;
    logic        take_trap;

    assign take_trap = (state == S_IDLE) && (error != 4'd0);

    // Architectural cause codes for the core's internal error classes;
    // unassigned codes land in the custom range starting at 24.
    always_comb begin
        mcause = 32'd24 + {28'd0, code_q};
        unique case (1'b1)
            (code_q == 4'd1): mcause = 32'd3;
            (code_q == 4'd2): mcause = 32'd24;
            (code_q == 4'd3): mcause = 32'd5;
            (code_q == 4'd4): mcause = 32'd2;
            default:          mcause = 32'd24 + {28'd0, code_q};
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (error != 4'd0)
                    state_nx = S_SET_MTVAL;
            end
            S_SET_MTVAL:  state_nx = S_SET_MEPC;
            S_SET_MEPC:   state_nx = S_SET_MCAUSE;
            S_SET_MCAUSE: state_nx = S_REDIRECT;
            S_REDIRECT:   state_nx = S_HANDLER;
            S_HANDLER: begin
                // A fault inside the handler wins over a concurrent mret.
                if (error != 4'd0)
                    state_nx = S_HALT;
                else if (mret_wb)
                    state_nx = S_RETURN;
            end
            S_RETURN: state_nx = S_IDLE;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_q <= 4'd0;
            info_q <= 32'd0;
            pc_q   <= 32'd0;
        end else if (take_trap) begin
            code_q <= error;
            info_q <= error_info;
            pc_q   <= error_pc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trap_count <= 16'd0;
        end else if (take_trap && (trap_count != 16'hFFFF)) begin
            trap_count <= trap_count + 16'd1;
        end
    end

    // HALT is only left through reset, so the state itself is the sticky flag.
    assign double_fault = (state == S_HALT);

    always_comb begin
        freeze      = 1'b0;
        flush       = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = 32'd0;
        csr_we      = 1'b0;
        csr_waddr   = 12'd0;
        csr_wdata   = 32'd0;
        in_trap     = 1'b0;
        case (state)
            S_SET_MTVAL: begin
                freeze    = 1'b1;
                flush     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = MTVAL_ADDR;
                csr_wdata = info_q;
            end
            S_SET_MEPC: begin
                freeze    = 1'b1;
                flush     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = MEPC_ADDR;
                csr_wdata = pc_q;
            end
            S_SET_MCAUSE: begin
                freeze    = 1'b1;
                flush     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = MCAUSE_ADDR;
                csr_wdata = mcause;
            end
            S_REDIRECT: begin
                // Direct mode only: mode bits of mtvec are masked off.
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = mtvec_in & 32'hFFFF_FFFC;
            end
            S_HANDLER: begin
                in_trap = 1'b1;
            end
            S_RETURN: begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = mepc_in & 32'hFFFF_FFFC;
            end
            S_HALT: begin
                freeze  = 1'b1;
                in_trap = 1'b1;
            end
            default: begin
                freeze = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer.
// Inputs change 1ns after the rising edge; outputs are checked there too.

module tb_trap_sequencer;

    logic        clk;
    logic        rstn;
    logic [3:0]  error;
    logic [31:0] error_info;
    logic [31:0] error_pc;
    logic        mret_wb;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic        freeze;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        in_trap;
    logic        double_fault;
    logic [15:0] trap_count;

    int errors = 0;
    int checks = 0;

    trap_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .error        (error),
        .error_info   (error_info),
        .error_pc     (error_pc),
        .mret_wb      (mret_wb),
        .mtvec_in     (mtvec_in),
        .mepc_in      (mepc_in),
        .freeze       (freeze),
        .flush        (flush),
        .pc_redirect  (pc_redirect),
        .redirect_pc  (redirect_pc),
        .csr_we       (csr_we),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .in_trap      (in_trap),
        .double_fault (double_fault),
        .trap_count   (trap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        error   = 4'd0;
        mret_wb = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        error = 4'd4;
        error_info = 32'hDEAD_BEEF;
        error_pc = 32'h0000_1234;
        rstn = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (csr_we !== 1'b0) begin
                errors++;
                $display("FAIL rst_csr_we got=%0h exp=0", csr_we);
            end
        end
        checks++;
        if ({freeze, flush, pc_redirect, in_trap, double_fault} !== 5'b0) begin
            errors++;
            $display("FAIL rst_flags got=%b exp=00000",
                     {freeze, flush, pc_redirect, in_trap, double_fault});
        end
        checks++;
        if ({redirect_pc, csr_waddr, csr_wdata, trap_count} !== 92'd0) begin
            errors++;
            $display("FAIL rst_buses got pc=%h a=%h d=%h cnt=%h exp=0",
                     redirect_pc, csr_waddr, csr_wdata, trap_count);
        end
        error = 4'd0;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_trap_entry();
        do_reset();
        mtvec_in = 32'h0000_0203;
        error = 4'd3;
        error_info = 32'h0000_1003;
        error_pc = 32'h0000_0040;
        tick();
        error = 4'd0;
        checks++;
        if ({csr_we, csr_waddr, csr_wdata} !== {1'b1, 12'h343, 32'h0000_1003}) begin
            errors++;
            $display("FAIL entry_mtval got we=%0h a=%h d=%h exp 1/343/00001003",
                     csr_we, csr_waddr, csr_wdata);
        end
        checks++;
        if ({freeze, flush} !== 2'b11) begin
            errors++;
            $display("FAIL entry_freeze_flush got=%b exp=11", {freeze, flush});
        end
        tick();
        checks++;
        if ({csr_we, csr_waddr, csr_wdata} !== {1'b1, 12'h341, 32'h0000_0040}) begin
            errors++;
            $display("FAIL entry_mepc got we=%0h a=%h d=%h exp 1/341/00000040",
                     csr_we, csr_waddr, csr_wdata);
        end
        tick();
        checks++;
        if ({csr_we, csr_waddr, csr_wdata} !== {1'b1, 12'h342, 32'd5}) begin
            errors++;
            $display("FAIL entry_mcause got we=%0h a=%h d=%h exp 1/342/00000005",
                     csr_we, csr_waddr, csr_wdata);
        end
        tick();
        checks++;
        if ({pc_redirect, redirect_pc} !== {1'b1, 32'h0000_0200}) begin
            errors++;
            $display("FAIL entry_redirect got v=%0h pc=%h exp 1/00000200",
                     pc_redirect, redirect_pc);
        end
        checks++;
        if ({freeze, flush, csr_we} !== 3'b010) begin
            errors++;
            $display("FAIL entry_redir_ctl got=%b exp=010", {freeze, flush, csr_we});
        end
        checks++;
        if (trap_count !== 16'd1) begin
            errors++;
            $display("FAIL entry_count got=%0d exp=1", trap_count);
        end
        tick();
        checks++;
        if ({in_trap, pc_redirect, flush, freeze} !== 4'b1000) begin
            errors++;
            $display("FAIL entry_handler got=%b exp=1000",
                     {in_trap, pc_redirect, flush, freeze});
        end
    endtask

    task automatic test_mret();
        mepc_in = 32'h0000_0044;
        mret_wb = 1'b1;
        tick();
        mret_wb = 1'b0;
        error = 4'd4;
        checks++;
        if ({pc_redirect, flush, redirect_pc} !== {2'b11, 32'h0000_0044}) begin
            errors++;
            $display("FAIL mret_redirect got v=%0h f=%0h pc=%h exp 1/1/00000044",
                     pc_redirect, flush, redirect_pc);
        end
        checks++;
        if (in_trap !== 1'b0) begin
            errors++;
            $display("FAIL mret_in_trap got=%0h exp=0", in_trap);
        end
        tick();
        error = 4'd0;
        checks++;
        if ({pc_redirect, flush, in_trap, csr_we} !== 4'b0000) begin
            errors++;
            $display("FAIL mret_idle got=%b exp=0000",
                     {pc_redirect, flush, in_trap, csr_we});
        end
        tick();
        checks++;
        if ({csr_we, trap_count} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL mret_err_ignored got we=%0h cnt=%0d exp 0/1",
                     csr_we, trap_count);
        end
    endtask

    task automatic test_held_error();
        int we_cnt;
        logic [31:0] cause;
        we_cnt = 0;
        cause = 32'hFFFF_FFFF;
        do_reset();
        mtvec_in = 32'h0000_0100;
        error = 4'd1;
        error_info = 32'h0000_0011;
        error_pc = 32'h0000_0080;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 4)
                error = 4'd0;
            if (csr_we === 1'b1)
                we_cnt++;
            if (csr_we === 1'b1 && csr_waddr === 12'h342)
                cause = csr_wdata;
        end
        checks++;
        if (we_cnt !== 3) begin
            errors++;
            $display("FAIL held_we_count got=%0d exp=3", we_cnt);
        end
        checks++;
        if (cause !== 32'd3) begin
            errors++;
            $display("FAIL held_mcause got=%0d exp=3", cause);
        end
        checks++;
        if (trap_count !== 16'd1) begin
            errors++;
            $display("FAIL held_count got=%0d exp=1", trap_count);
        end
        checks++;
        if ({in_trap, double_fault} !== 2'b10) begin
            errors++;
            $display("FAIL held_state got=%b exp=10", {in_trap, double_fault});
        end
    endtask

    task automatic test_double_fault();
        error = 4'd2;
        mret_wb = 1'b1;
        mepc_in = 32'h0000_0300;
        tick();
        error = 4'd0;
        mret_wb = 1'b0;
        checks++;
        if ({double_fault, freeze, in_trap, pc_redirect, flush} !== 5'b11100) begin
            errors++;
            $display("FAIL dfault_enter got=%b exp=11100",
                     {double_fault, freeze, in_trap, pc_redirect, flush});
        end
        for (int i = 0; i < 4; i++) begin
            error = 4'd4;
            mret_wb = i[0];
            tick();
        end
        error = 4'd0;
        mret_wb = 1'b0;
        checks++;
        if ({double_fault, freeze, pc_redirect, csr_we} !== 4'b1100) begin
            errors++;
            $display("FAIL dfault_sticky got=%b exp=1100",
                     {double_fault, freeze, pc_redirect, csr_we});
        end
        checks++;
        if (trap_count !== 16'd1) begin
            errors++;
            $display("FAIL dfault_count got=%0d exp=1", trap_count);
        end
        do_reset();
        checks++;
        if ({double_fault, freeze} !== 2'b00) begin
            errors++;
            $display("FAIL dfault_reset got=%b exp=00", {double_fault, freeze});
        end
    endtask

    task automatic test_mcause_map();
        logic [3:0]  codes [5];
        logic [31:0] exp_c [5];
        codes = '{4'd4, 4'd5, 4'd15, 4'd2, 4'd1};
        exp_c = '{32'd2, 32'd29, 32'd39, 32'd24, 32'd3};
        for (int k = 0; k < 5; k++) begin
            do_reset();
            error = codes[k];
            tick();
            error = 4'd0;
            tick();
            tick();
            checks++;
            if ({csr_waddr, csr_wdata} !== {12'h342, exp_c[k]}) begin
                errors++;
                $display("FAIL mcause_code%0d got a=%h d=%0d exp 342/%0d",
                         codes[k], csr_waddr, csr_wdata, exp_c[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        error = 4'd3;
        tick();
        error = 4'd0;
        tick();
        checks++;
        if ({csr_we, csr_waddr} !== {1'b1, 12'h341}) begin
            errors++;
            $display("FAIL midrst_pre got we=%0h a=%h exp 1/341", csr_we, csr_waddr);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({csr_we, freeze, flush, trap_count} !== {3'b000, 16'd0}) begin
            errors++;
            $display("FAIL midrst_async got we=%0h fz=%0h fl=%0h cnt=%0d exp 0",
                     csr_we, freeze, flush, trap_count);
        end
        tick();
        rstn = 1'b1;
        tick();
        checks++;
        if ({csr_we, in_trap, pc_redirect} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_idle got=%b exp=000", {csr_we, in_trap, pc_redirect});
        end
    endtask

    initial begin
        rstn = 1'b0;
        error = 4'd0;
        error_info = 32'd0;
        error_pc = 32'd0;
        mret_wb = 1'b0;
        mtvec_in = 32'd0;
        mepc_in = 32'd0;
        test_reset();
        test_trap_entry();
        test_mret();
        test_held_error();
        test_double_fault();
        test_mcause_map();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
